// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: select codes, flag positions,
// FSM states and the control fields held across a load's wait cycle.
package wb_stage_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic              we;
    logic [FLAG_W-1:0] mask;
    logic [FLAG_W-1:0] flags;
  } pend_ctl_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic o, input logic s,
                                                   input logic c, input logic z);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_O] = o;
    f[FLAG_S] = s;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// EX-to-WB bundle plus the register-bank, flag and PC-redirect outputs.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_O, alu_S, alu_C, alu_Z;
  logic [DATA_W-1:0] dm_Q;
  logic              tf_out;
  logic [1:0]        uc_S_MXWB;
  logic              uc_WE;
  logic [3:0]        uc_WE_FLAGS;
  logic              uc_IS_LOAD;
  logic              uc_IS_JUMP;
  logic [RA_W-1:0]   rd_addr;
  logic [DATA_W-1:0] pc_plus1;
  logic [DATA_W-1:0] jump_target;
  logic              rb_WE;
  logic [RA_W-1:0]   rb_WA;
  logic [DATA_W-1:0] rb_WD;
  logic              rf_O, rf_S, rf_C, rf_Z;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              flush;

  modport master (
    output ex_valid, alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, tf_out,
           uc_S_MXWB, uc_WE, uc_WE_FLAGS, uc_IS_LOAD, uc_IS_JUMP, rd_addr,
           pc_plus1, jump_target,
    input  ex_ready, rb_WE, rb_WA, rb_WD, rf_O, rf_S, rf_C, rf_Z,
           pc_load, pc_target, flush
  );

  modport slave (
    input  ex_valid, alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, tf_out,
           uc_S_MXWB, uc_WE, uc_WE_FLAGS, uc_IS_LOAD, uc_IS_JUMP, rd_addr,
           pc_plus1, jump_target,
    output ex_ready, rb_WE, rb_WA, rb_WD, rf_O, rf_S, rf_C, rf_Z,
           pc_load, pc_target, flush
  );
endinterface

// File: rtl/wb_stage_flag_reg.sv
// Architectural {O,S,C,Z} register; each bit loads only when its mask bit is set.
module wb_stage_flag_reg
  import wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] wr_mask,
  input  logic [FLAG_W-1:0] wr_val,
  output logic [FLAG_W-1:0] flags
);

  logic [FLAG_W-1:0] flags_d, flags_q;

  always_comb begin
    flags_d = (flags_q & ~wr_mask) | (wr_val & wr_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits register writes and flags, turns taken jumps into
// a PC load plus one flush cycle, and stalls one cycle for load data.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input logic       CLK,
  input logic       RST,
  wb_stage_if.slave bus
);

  wb_state_e         state_d, state_q;
  logic              ex_ready_d, ex_ready_q;
  logic              rb_we_d, rb_we_q;
  logic [RA_W-1:0]   rb_wa_d, rb_wa_q;
  logic [DATA_W-1:0] rb_wd_d, rb_wd_q;
  logic              pc_load_d, pc_load_q;
  logic              flush_d, flush_q;
  logic [DATA_W-1:0] pc_target_d, pc_target_q;
  pend_ctl_t         pend_d, pend_q;
  logic [RA_W-1:0]   pend_wa_d, pend_wa_q;
  logic              accept_c;
  logic [FLAG_W-1:0] flag_mask_c, flag_val_c, flags;

  always_comb begin
    state_d     = state_q;
    ex_ready_d  = 1'b1;
    rb_we_d     = 1'b0;
    rb_wa_d     = rb_wa_q;
    rb_wd_d     = rb_wd_q;
    pc_load_d   = 1'b0;
    flush_d     = 1'b0;
    pc_target_d = pc_target_q;
    pend_d      = pend_q;
    pend_wa_d   = pend_wa_q;
    flag_mask_c = '0;
    flag_val_c  = '0;
    accept_c    = bus.ex_valid & ex_ready_q;

    unique case (state_q)
      RUN: begin
        if (accept_c) begin
          if (bus.uc_IS_LOAD) begin
            // Load wins over a simultaneous jump; everything but the data waits a cycle.
            state_d    = LOAD_WAIT;
            ex_ready_d = 1'b0;
            pend_d     = '{we:    bus.uc_WE,
                           mask:  bus.uc_WE_FLAGS,
                           flags: pack_flags(bus.alu_O, bus.alu_S, bus.alu_C, bus.alu_Z)};
            pend_wa_d  = bus.rd_addr;
          end else begin
            rb_we_d = bus.uc_WE & (bus.rd_addr != '0);
            rb_wa_d = bus.rd_addr;
            case (bus.uc_S_MXWB)
              WB_MEM:  rb_wd_d = bus.dm_Q;
              WB_LINK: rb_wd_d = bus.pc_plus1;
              default: rb_wd_d = bus.alu_result;
            endcase
            flag_mask_c = bus.uc_WE_FLAGS;
            flag_val_c  = pack_flags(bus.alu_O, bus.alu_S, bus.alu_C, bus.alu_Z);
            if (bus.uc_IS_JUMP & bus.tf_out) begin
              pc_load_d   = 1'b1;
              flush_d     = 1'b1;
              pc_target_d = bus.jump_target;
              ex_ready_d  = 1'b0;
            end
          end
        end
      end
      LOAD_WAIT: begin
        state_d     = RUN;
        rb_we_d     = pend_q.we & (pend_wa_q != '0);
        rb_wa_d     = pend_wa_q;
        rb_wd_d     = bus.dm_Q;
        flag_mask_c = pend_q.mask;
        flag_val_c  = pend_q.flags;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      ex_ready_q  <= 1'b1;
      rb_we_q     <= 1'b0;
      rb_wa_q     <= '0;
      rb_wd_q     <= '0;
      pc_load_q   <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= '0;
      pend_q      <= '0;
      pend_wa_q   <= '0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= ex_ready_d;
      rb_we_q     <= rb_we_d;
      rb_wa_q     <= rb_wa_d;
      rb_wd_q     <= rb_wd_d;
      pc_load_q   <= pc_load_d;
      flush_q     <= flush_d;
      pc_target_q <= pc_target_d;
      pend_q      <= pend_d;
      pend_wa_q   <= pend_wa_d;
    end
  end

  wb_stage_flag_reg u_flags (
    .clk     (CLK),
    .rst     (RST),
    .wr_mask (flag_mask_c),
    .wr_val  (flag_val_c),
    .flags   (flags)
  );

  assign bus.ex_ready  = ex_ready_q;
  assign bus.rb_WE     = rb_we_q;
  assign bus.rb_WA     = rb_wa_q;
  assign bus.rb_WD     = rb_wd_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.flush     = flush_q;
  assign bus.pc_target = pc_target_q;
  assign bus.rf_O      = flags[FLAG_O];
  assign bus.rf_S      = flags[FLAG_S];
  assign bus.rf_C      = flags[FLAG_C];
  assign bus.rf_Z      = flags[FLAG_Z];

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a per-cycle commit schedule model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_stage;

  localparam int N = 256;

  logic CLK = 1'b0;
  logic RST;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   rst_seen = 1'b0;
  bit   started  = 1'b0;

  wb_stage_if bus ();

  wb_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Schedule indexed by cycle: what must become visible in that cycle.
  bit          blocked [N];
  bit          rst_at  [N];
  bit          cm_valid[N];
  bit          cm_we   [N];
  logic [4:0]  cm_wa   [N];
  logic [31:0] cm_wd   [N];
  bit          cm_mem  [N];
  logic [3:0]  cm_mask [N];
  logic [3:0]  cm_fl   [N];
  bit          cm_jump [N];
  logic [31:0] cm_tgt  [N];
  logic [31:0] dmq_at  [N];

  logic [4:0]  h_wa;
  logic [31:0] h_wd, h_tgt;
  logic [3:0]  h_fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    else
      passed++;
  endtask

  // Model: decides acceptance from the schedule and books each commit.
  always @(posedge CLK) begin : model
    int c;
    logic [3:0] fl;
    c  = cyc;
    fl = {bus.alu_O, bus.alu_S, bus.alu_C, bus.alu_Z};
    if (c + 2 < N) begin
      dmq_at[c] = bus.dm_Q;
      if (RST) begin
        rst_seen      = 1'b1;
        rst_at[c+1]   = 1'b1;
        cm_valid[c+1] = 1'b0;
        blocked[c+1]  = 1'b0;
      end else if (rst_seen && bus.ex_valid && !blocked[c]) begin
        if (bus.uc_IS_LOAD) begin
          blocked[c+1]  = 1'b1;
          cm_valid[c+2] = 1'b1;
          cm_we[c+2]    = bus.uc_WE;
          cm_wa[c+2]    = bus.rd_addr;
          cm_mem[c+2]   = 1'b1;
          cm_mask[c+2]  = bus.uc_WE_FLAGS;
          cm_fl[c+2]    = fl;
          cm_jump[c+2]  = 1'b0;
        end else begin
          cm_valid[c+1] = 1'b1;
          cm_we[c+1]    = bus.uc_WE;
          cm_wa[c+1]    = bus.rd_addr;
          cm_mem[c+1]   = 1'b0;
          case (bus.uc_S_MXWB)
            2'd1:    cm_wd[c+1] = bus.dm_Q;
            2'd2:    cm_wd[c+1] = bus.pc_plus1;
            default: cm_wd[c+1] = bus.alu_result;
          endcase
          cm_mask[c+1] = bus.uc_WE_FLAGS;
          cm_fl[c+1]   = fl;
          cm_jump[c+1] = bus.uc_IS_JUMP && bus.tf_out;
          cm_tgt[c+1]  = bus.jump_target;
          if (bus.uc_IS_JUMP && bus.tf_out) blocked[c+1] = 1'b1;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge CLK) begin : compare
    int k;
    bit e_we, e_jmp;
    k = cyc;
    if (k < N && k > 0) begin
      if (rst_at[k]) begin
        started = 1'b1;
        h_wa = '0; h_wd = '0; h_tgt = '0; h_fl = '0;
      end
      if (cm_valid[k]) begin
        h_wa = cm_wa[k];
        h_wd = cm_mem[k] ? dmq_at[k-1] : cm_wd[k];
        h_fl = (h_fl & ~cm_mask[k]) | (cm_fl[k] & cm_mask[k]);
        if (cm_jump[k]) h_tgt = cm_tgt[k];
      end
      e_we  = cm_valid[k] && cm_we[k] && (cm_wa[k] != 5'd0);
      e_jmp = cm_valid[k] && cm_jump[k];
      if (started) begin
        chk("m_ex_ready",  32'(bus.ex_ready),  32'(!blocked[k]));
        chk("m_rb_we",     32'(bus.rb_WE),     32'(e_we));
        chk("m_rb_wa",     32'(bus.rb_WA),     32'(h_wa));
        chk("m_rb_wd",     bus.rb_WD,          h_wd);
        chk("m_pc_load",   32'(bus.pc_load),   32'(e_jmp));
        chk("m_flush",     32'(bus.flush),     32'(e_jmp));
        chk("m_pc_target", bus.pc_target,      h_tgt);
        chk("m_flags",     32'({bus.rf_O, bus.rf_S, bus.rf_C, bus.rf_Z}), 32'(h_fl));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic we, input logic [1:0] sel, input logic [3:0] mask,
                       input logic [3:0] fl, input logic ld, input logic jmp, input logic tf);
    bus.ex_valid    = v;
    bus.alu_result  = res;
    bus.rd_addr     = rd;
    bus.uc_WE       = we;
    bus.uc_S_MXWB   = sel;
    bus.uc_WE_FLAGS = mask;
    bus.alu_O       = fl[3];
    bus.alu_S       = fl[2];
    bus.alu_C       = fl[1];
    bus.alu_Z       = fl[0];
    bus.uc_IS_LOAD  = ld;
    bus.uc_IS_JUMP  = jmp;
    bus.tf_out      = tf;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] flags_now();
    return 32'({bus.rf_O, bus.rf_S, bus.rf_C, bus.rf_Z});
  endfunction

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    RST = 1'b1;
    idle();
    bus.dm_Q        = 32'h0;
    bus.pc_plus1    = 32'h0;
    bus.jump_target = 32'h0;
    tick(); tick();
    RST = 1'b0;
    chk("L_reset_ready", 32'(bus.ex_ready), 32'd1);
    chk("L_reset_we",    32'(bus.rb_WE),    32'd0);
    chk("L_reset_flags", flags_now(),       32'd0);

    // ALU op
    drive(1'b1, 32'h0000_00AA, 5'd3, 1'b1, 2'd0, 4'hF, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("L_alu_we",    32'(bus.rb_WE), 32'd1);
    chk("L_alu_wa",    32'(bus.rb_WA), 32'd3);
    chk("L_alu_wd",    bus.rb_WD,      32'hAA);
    chk("L_alu_flags", flags_now(),    32'b0010);

    // Load with one wait cycle
    drive(1'b1, 32'h0, 5'd7, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("L_ld_ready0", 32'(bus.ex_ready), 32'd0);
    chk("L_ld_we0",    32'(bus.rb_WE),    32'd0);
    idle();
    bus.dm_Q = 32'h1234_5678;
    tick();
    chk("L_ld_we",  32'(bus.rb_WE), 32'd1);
    chk("L_ld_wa",  32'(bus.rb_WA), 32'd7);
    chk("L_ld_wd",  bus.rb_WD,      32'h1234_5678);
    tick();
    chk("L_ld_once", 32'(bus.rb_WE), 32'd0);

    // Taken jump with link, then a wrong-path instruction in the flush cycle
    bus.pc_plus1    = 32'h11;
    bus.jump_target = 32'h40;
    drive(1'b1, 32'h5, 5'd31, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("L_jmp_pcl",   32'(bus.pc_load),  32'd1);
    chk("L_jmp_flush", 32'(bus.flush),    32'd1);
    chk("L_jmp_tgt",   bus.pc_target,     32'h40);
    chk("L_jmp_wd",    bus.rb_WD,         32'h11);
    chk("L_jmp_ready", 32'(bus.ex_ready), 32'd0);
    drive(1'b1, 32'h99, 5'd5, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("L_wrongpath_we",    32'(bus.rb_WE),   32'd0);
    chk("L_wrongpath_pcl",   32'(bus.pc_load), 32'd0);
    chk("L_wrongpath_flags", flags_now(),      32'b0010);
    // Not-taken jump
    drive(1'b1, 32'h5, 5'd31, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("L_nt_pcl",   32'(bus.pc_load), 32'd0);
    chk("L_nt_flush", 32'(bus.flush),   32'd0);
    chk("L_nt_we",    32'(bus.rb_WE),   32'd1);

    // Masked flag update and r0 write suppression
    drive(1'b1, 32'h0, 5'd4, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("L_flags_all1", flags_now(), 32'b1111);
    drive(1'b1, 32'h0, 5'd4, 1'b0, 2'd0, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("L_flags_maskz", flags_now(), 32'b1110);
    drive(1'b1, 32'h77, 5'd0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("L_r0_we", 32'(bus.rb_WE), 32'd0);

    // Reset while a load is pending
    drive(1'b1, 32'h0, 5'd9, 1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    tick();
    chk("L_rstld_ready0", 32'(bus.ex_ready), 32'd0);
    RST = 1'b1;
    idle();
    bus.dm_Q = 32'hDEAD_BEEF;
    tick();
    chk("L_rstld_we",    32'(bus.rb_WE),    32'd0);
    chk("L_rstld_flags", flags_now(),       32'd0);
    chk("L_rstld_wd",    bus.rb_WD,         32'd0);
    chk("L_rstld_tgt",   bus.pc_target,     32'd0);
    chk("L_rstld_ready", 32'(bus.ex_ready), 32'd1);
    RST = 1'b0;
    tick();
    chk("L_rstld_we2",    32'(bus.rb_WE),    32'd0);
    chk("L_rstld_ready2", 32'(bus.ex_ready), 32'd1);

    // Back-to-back ALU ops
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 5'(i), 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("L_b2b_we", 32'(bus.rb_WE), 32'd1);
      chk("L_b2b_wd", bus.rb_WD,      32'(i));
    end
    idle();
    tick();
    chk("L_b2b_end", 32'(bus.rb_WE), 32'd0);
    tick(); tick();
    #10;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
